// File: rtl/mem_sram_bridge_pkg.sv
// mem_sram_bridge_pkg: shared types and constants for the MEM-stage SRAM bridge.
//   br_state_e : bridge FSM encodings (BR_IDLE .. BR_DRAIN)
//   SZ_*       : bus size codes carried on data_size
package mem_sram_bridge_pkg;

   typedef enum logic [2:0] {
      BR_IDLE  = 3'd0,
      BR_REQ   = 3'd1,
      BR_WAIT  = 3'd2,
      BR_DONE  = 3'd3,
      BR_DRAIN = 3'd4
   } br_state_e;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem_sram_bridge_if.sv
// mem_sram_bridge_if: groups the pipeline-side and SRAM-bus-side signals of the bridge.
//   Pipeline in : mem_en, mem_wr, mem_size, mem_wen, mem_addr, mem_wdata, mem_except,
//                 flush, mem_advance
//   Pipeline out: stall_req, rdata_out
//   Bus out     : data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb
//   Bus in      : data_addr_ok, data_data_ok, data_rdata
// Modports: master = the bridge (bus master), slave = pipeline plus memory environment.
interface mem_sram_bridge_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic                  mem_en;
   logic                  mem_wr;
   logic [1:0]            mem_size;
   logic [DATA_W/8-1:0]   mem_wen;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic                  mem_except;
   logic                  flush;
   logic                  mem_advance;

   logic                  data_req;
   logic                  data_wr;
   logic [1:0]            data_size;
   logic [ADDR_W-1:0]     data_addr;
   logic [DATA_W-1:0]     data_wdata;
   logic [DATA_W/8-1:0]   data_wstrb;
   logic                  data_addr_ok;
   logic                  data_data_ok;
   logic [DATA_W-1:0]     data_rdata;

   logic                  stall_req;
   logic [DATA_W-1:0]     rdata_out;

   modport master (
      input  mem_en, mem_wr, mem_size, mem_wen, mem_addr, mem_wdata, mem_except,
      input  flush, mem_advance, data_addr_ok, data_data_ok, data_rdata,
      output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
      output stall_req, rdata_out
   );

   modport slave (
      output mem_en, mem_wr, mem_size, mem_wen, mem_addr, mem_wdata, mem_except,
      output flush, mem_advance, data_addr_ok, data_data_ok, data_rdata,
      input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
      input  stall_req, rdata_out
   );
endinterface

// File: rtl/mem_addr_map.sv
// mem_addr_map: fixed kseg0/kseg1 VA->PA translation (combinational).
//   i_vaddr : virtual byte address
//   o_paddr : physical address; top three bits cleared when i_vaddr is in kseg0/kseg1
module mem_addr_map #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] i_vaddr,
   output logic [ADDR_W-1:0] o_paddr
);
   always_comb begin
      o_paddr = i_vaddr;
      if (i_vaddr[ADDR_W-1 -: 2] == 2'b10) begin
         o_paddr = {3'b000, i_vaddr[ADDR_W-4:0]};
      end
   end
endmodule

// File: rtl/mem_sram_bridge.sv
// mem_sram_bridge: MEM-stage bridge from the load/store lane selector to an SRAM-like bus
// (req/addr_ok/data_ok). One transaction outstanding at a time; stalls the pipeline until the
// access completes and holds the raw read word until the stage advances. A flush after the
// request was accepted drains the pending response before returning to idle.
//   i_clk    : system clock
//   i_resetn : synchronous active-low reset (abandons any transaction without draining)
//   io_bus   : mem_sram_bridge_if.master (pipeline and bus signals)
// Build option: MEM_BRIDGE_ADDR_MAP_EN enables kseg0/kseg1 translation of data_addr.
module mem_sram_bridge
   import mem_sram_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input logic               i_clk,
   input logic               i_resetn,
   mem_sram_bridge_if.master io_bus
);
   localparam int unsigned STRB_W = DATA_W / 8;

   br_state_e           r_state;
   br_state_e           w_state_nxt;
   logic                w_issue;
   logic                w_capture;
   logic                w_req_drop;
   logic                w_stall;
   logic [ADDR_W-1:0]   w_addr;

   logic                r_req;
   logic                r_wr;
   logic [1:0]          r_size;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [STRB_W-1:0]   r_wstrb;
   logic [DATA_W-1:0]   r_rdata;

`ifdef MEM_BRIDGE_ADDR_MAP_EN
   mem_addr_map #(
      .ADDR_W (ADDR_W)
   ) u_addr_map (
      .i_vaddr (io_bus.mem_addr),
      .o_paddr (w_addr)
   );
`else
   assign w_addr = io_bus.mem_addr;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_capture   = 1'b0;
      w_req_drop  = 1'b0;
      unique case (r_state)
         BR_IDLE: begin
            if (io_bus.mem_en && !io_bus.mem_except && !io_bus.flush) begin
               w_issue     = 1'b1;
               w_state_nxt = BR_REQ;
            end
         end
         BR_REQ: begin
            // data_ok cannot coincide with addr_ok, so it is not looked at here.
            if (io_bus.flush) begin
               w_req_drop  = 1'b1;
               w_state_nxt = io_bus.data_addr_ok ? BR_DRAIN : BR_IDLE;
            end else if (io_bus.data_addr_ok) begin
               w_req_drop  = 1'b1;
               w_state_nxt = BR_WAIT;
            end
         end
         BR_WAIT: begin
            if (io_bus.flush) begin
               // A response landing with the flush is simply dropped.
               w_state_nxt = io_bus.data_data_ok ? BR_IDLE : BR_DRAIN;
            end else if (io_bus.data_data_ok) begin
               w_capture   = !r_wr;
               w_state_nxt = BR_DONE;
            end
         end
         BR_DONE: begin
            if (io_bus.flush || io_bus.mem_advance) begin
               w_state_nxt = BR_IDLE;
            end
         end
         BR_DRAIN: begin
            if (io_bus.data_data_ok) begin
               w_state_nxt = BR_IDLE;
            end
         end
         default: w_state_nxt = BR_IDLE;
      endcase
   end

   always_comb begin
      w_stall = 1'b0;
      if (r_state == BR_DRAIN) begin
         w_stall = 1'b1;
      end else if (r_state == BR_IDLE || r_state == BR_REQ || r_state == BR_WAIT) begin
         w_stall = io_bus.mem_en && !io_bus.mem_except;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_state <= BR_IDLE;
         r_req   <= 1'b0;
         r_wr    <= 1'b0;
         r_size  <= SZ_BYTE;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
         r_rdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_issue) begin
            r_req   <= 1'b1;
            r_wr    <= io_bus.mem_wr;
            r_size  <= io_bus.mem_size;
            r_addr  <= w_addr;
            r_wdata <= io_bus.mem_wdata;
            r_wstrb <= io_bus.mem_wr ? io_bus.mem_wen : '0;
         end else if (w_req_drop) begin
            r_req <= 1'b0;
         end
         if (w_capture) begin
            r_rdata <= io_bus.data_rdata;
         end
      end
   end

   assign io_bus.data_req   = r_req;
   assign io_bus.data_wr    = r_wr;
   assign io_bus.data_size  = r_size;
   assign io_bus.data_addr  = r_addr;
   assign io_bus.data_wdata = r_wdata;
   assign io_bus.data_wstrb = r_wstrb;
   assign io_bus.rdata_out  = r_rdata;
   assign io_bus.stall_req  = w_stall;

endmodule

// File: doc/mem_sram_bridge.md
Name: mem_sram_bridge

Overview:
- MEM-stage data-memory bridge sitting directly downstream of the MEM-stage load/store lane selector.
- Takes the selector's byte enables, replicated write data, address and exception flags. Issues one SRAM-like bus transaction (req/addr_ok/data_ok) per access.
- Stalls the pipeline until the access completes. Returns raw read data to the selector for lane extraction.
- Handles exception flush mid-transaction by draining outstanding responses.

Parameters:
- ADDR_W, 32, bus address width.
- DATA_W, 32, bus data width; DATA_W/8 byte enables.

Ports:
- clk  in  1  system clock (single clock domain).
- resetn  in  1  synchronous, active-low reset.
- mem_en  in  1  MEM stage holds a valid load or store.
- mem_wr  in  1  1 = store, 0 = load.
- mem_size  in  2  0 = byte, 1 = half, 2 = word.
- mem_wen  in  4  byte enables from lane selector (0 for loads or faulting stores).
- mem_addr  in  ADDR_W  byte address.
- mem_wdata  in  DATA_W  lane-replicated store data.
- mem_except  in  1  adel/ades raised for this access; suppresses the request.
- flush  in  1  exception/eret flush of MEM stage.
- mem_advance  in  1  pipeline moves MEM->WB this cycle.
- data_req  out  1  bus request.
- data_wr  out  1  bus write.
- data_size  out  2  bus size.
- data_addr  out  ADDR_W  bus address.
- data_wdata  out  DATA_W  bus write data.
- data_wstrb  out  4  bus byte strobes.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  response / write-ack valid.
- data_rdata  in  DATA_W  read response.
- stall_req  out  1  MEM stall request to hazard unit.
- rdata_out  out  DATA_W  raw read word, held until mem_advance.

Behaviour:
- Reset (resetn=0 at posedge):
  - state = IDLE.
  - data_req = 0; data_wr, data_size, data_addr, data_wdata, data_wstrb, rdata_out = 0.
  - Reset mid-transaction abandons it with no drain.
- Bus outputs are registered and latched at issue. They stay stable while data_req = 1.
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE:
  - If mem_en & ~mem_except & ~flush: latch the access; next state REQ (data_req = 1 from the next cycle).
  - Otherwise stay in IDLE.
- REQ:
  - data_addr_ok = 1 -> WAIT; data_req drops the next cycle.
  - data_data_ok is ignored in REQ (a response never arrives in the same cycle as addr_ok).
- WAIT:
  - data_data_ok = 1 -> capture data_rdata into rdata_out (stores capture nothing) -> DONE.
- DONE:
  - rdata_out is held.
  - mem_advance = 1 -> IDLE.
  - A new access may issue no earlier than the cycle after leaving DONE.
- stall_req (combinational):
  - 1 when mem_en & ~mem_except & state in {IDLE, REQ, WAIT}.
  - 1 whenever state = DRAIN, regardless of mem_en.
  - 0 in DONE.
  - Minimum access latency: 3 stall cycles (IDLE, REQ, WAIT) with addr_ok and data_ok each on their first possible cycle.
- Flush:
  - IDLE or DONE -> IDLE.
  - REQ without addr_ok -> IDLE; data_req withdrawn next cycle.
  - REQ with addr_ok in the same cycle -> DRAIN.
  - WAIT without data_ok -> DRAIN.
  - WAIT with data_ok in the same cycle -> IDLE, response discarded.
- DRAIN: wait for data_data_ok, discard the response (rdata_out unchanged), then -> IDLE.
- mem_except = 1: no bus activity; stall_req = 0; exception proceeds down the pipeline.
- Exactly one outstanding transaction at any time.
- data_wstrb = mem_wen for stores, 0 for loads.

Optional Feature:
- MEM_BRIDGE_ADDR_MAP_EN.
  - Defined: fixed kseg0/kseg1 mapping. If mem_addr[31:30] == 2'b10, data_addr = {3'b000, mem_addr[28:0]}; otherwise pass-through.
  - Undefined: data_addr = mem_addr unchanged.

Decomposition:
- Shared package/header defines.vh gains:
  - State encodings BR_IDLE, BR_REQ, BR_WAIT, BR_DONE, BR_DRAIN.
  - Size codes SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2.
- One natural sub-module, mem_addr_map: combinational VA->PA translation, instantiated only under MEM_BRIDGE_ADDR_MAP_EN.

Test Plan:
- LW @0x00000104, addr_ok on first REQ cycle, data_ok one cycle later with 0xDEADBEEF -> data_req high exactly 1 cycle, stall_req high 3 cycles, rdata_out = 0xDEADBEEF in DONE, IDLE after mem_advance.
- SB @0x00000103, wen 4'b1000, wdata 0x5A5A5A5A, addr_ok delayed 4 cycles -> data_req/addr/wstrb/wdata stable all 5 REQ cycles, data_wr = 1, data_size = 0, rdata_out unchanged.
- LH @0x00000101 with mem_except = 1 -> data_req never asserts, stall_req = 0.
- LW, flush in the same cycle as addr_ok, data_ok 2 cycles later with 0x11112222 -> DRAIN, stall_req = 1 through data_ok, rdata_out keeps its prior value, back to IDLE.
- Flush in REQ without addr_ok -> data_req low next cycle, IDLE, no further bus activity.
- Macro on: LW @0xA0001000 -> data_addr = 0x00001000; @0x00400000 -> unchanged. Reset asserted mid-WAIT -> all outputs 0 next cycle.
